// File: rtl/mmio_port_bank.sv
// mmio_port_bank
//   Memory-mapped I/O port bank that sits beside the data RAM on the CPU
//   mem_cmd/mem_addr bus. It provides N_OUT writable output registers,
//   N_IN synchronised input ports and, optionally, sticky rising-edge status
//   bits with an interrupt line. Read data is registered, so its latency
//   matches the synchronous RAM; the top level muxes RAM dout against
//   read_data using rd_hit.
//
//   Address window (off = mem_addr - BASE_ADDR, BASE_ADDR low 8 bits zero):
//     0x00+i  OUT[i]   read/write
//     0x40+i  IN[i]    read-only, synchronised value
//     0x80+i  STAT[i]  read / write-1-to-clear (MMIO_EDGE_CAPTURE_EN only)
//
//   Build option: define MMIO_EDGE_CAPTURE_EN to include the edge-detect
//   flops, STAT registers, STAT decode and irq. Without it, irq is tied to 0
//   and STAT addresses are not decoded.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-high
//   mem_cmd     2'b00 none, 2'b01 read, 2'b11 write, 2'b10 treated as none
//   mem_addr    word address
//   write_data  CPU store data
//   read_data   registered read data, 0 when rd_hit=0
//   rd_hit      registered; read_data is valid from this block
//   in_ports    asynchronous inputs, port i at [i*PORT_W +: PORT_W]
//   out_ports   output register contents, same packing
//   irq         OR of all STAT bits

module mmio_port_bank #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 9,
    parameter int                 PORT_W    = 8,
    parameter int                 N_OUT     = 2,
    parameter int                 N_IN      = 2,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 9'h100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mem_cmd,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       write_data,
    output logic [DATA_W-1:0]       read_data,
    output logic                    rd_hit,
    input  logic [N_IN*PORT_W-1:0]  in_ports,
    output logic [N_OUT*PORT_W-1:0] out_ports,
    output logic                    irq
);

    logic [N_OUT*PORT_W-1:0] out_q;
    logic [N_IN*PORT_W-1:0]  sync1;
    logic [N_IN*PORT_W-1:0]  sync2;

    logic                    in_window;
    logic [7:0]              off;
    logic                    is_rd;
    logic                    is_wr;
    logic                    rd_dec;
    logic [DATA_W-1:0]       rd_val;
    logic [N_OUT-1:0]        out_sel;

    // Upper write_data bits beyond PORT_W are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^write_data;

`ifdef MMIO_EDGE_CAPTURE_EN
    logic [N_IN*PORT_W-1:0]  prev;
    logic [N_IN*PORT_W-1:0]  stat;
    logic [N_IN*PORT_W-1:0]  stat_clr;
`endif

    assign in_window = (mem_addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
    assign off       = mem_addr[7:0];
    assign is_rd     = (mem_cmd == 2'b01);
    assign is_wr     = (mem_cmd == 2'b11);
    assign out_ports = out_q;

    // Address decode and read mux; the write-1 clear mask is only meaningful
    // when qualified by is_wr in the STAT update below.
    always_comb begin
        rd_dec  = 1'b0;
        rd_val  = '0;
        out_sel = '0;
`ifdef MMIO_EDGE_CAPTURE_EN
        stat_clr = '0;
`endif
        if (in_window) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (off == 8'(i)) begin
                    rd_dec               = 1'b1;
                    rd_val[PORT_W-1:0]   = out_q[i*PORT_W +: PORT_W];
                    out_sel[i]           = 1'b1;
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (off == 8'(64 + i)) begin
                    rd_dec               = 1'b1;
                    rd_val[PORT_W-1:0]   = sync2[i*PORT_W +: PORT_W];
                end
            end
`ifdef MMIO_EDGE_CAPTURE_EN
            for (int i = 0; i < N_IN; i++) begin
                if (off == 8'(128 + i)) begin
                    rd_dec                       = 1'b1;
                    rd_val[PORT_W-1:0]           = stat[i*PORT_W +: PORT_W];
                    stat_clr[i*PORT_W +: PORT_W] = write_data[PORT_W-1:0];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            sync1     <= '0;
            sync2     <= '0;
            read_data <= '0;
            rd_hit    <= 1'b0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (is_wr && out_sel[i])
                    out_q[i*PORT_W +: PORT_W] <= write_data[PORT_W-1:0];
            end
            sync1     <= in_ports;
            sync2     <= sync1;
            rd_hit    <= is_rd && rd_dec;
            read_data <= (is_rd && rd_dec) ? rd_val : '0;
        end
    end

`ifdef MMIO_EDGE_CAPTURE_EN
    // Set term is OR'd after the clear so a coincident rising edge wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
            stat <= '0;
        end else begin
            prev <= sync2;
            stat <= (stat & ~(is_wr ? stat_clr : '0)) | (sync2 & ~prev);
        end
    end

    assign irq = |stat;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb_mmio_port_bank
//   Directed self-checking bench for mmio_port_bank with default parameters
//   (DATA_W=16, ADDR_W=9, PORT_W=8, N_OUT=N_IN=2, BASE_ADDR=9'h100).
//   STAT/irq scenarios follow MMIO_EDGE_CAPTURE_EN; the default build checks
//   that STAT is absent.

module tb_mmio_port_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;
    logic        rd_hit;
    logic [15:0] in_ports = '0;
    logic [15:0] out_ports;
    logic        irq;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b11;

    mmio_port_bank dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_hit     (rd_hit),
        .in_ports   (in_ports),
        .out_ports  (out_ports),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Presents one bus command for one cycle; returns 1 time unit after the
    // edge that sampled it, with the bus back to idle.
    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_cmd    = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data: got %h want 0000", read_data); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL reset_rd_hit: got %b want 0", rd_hit); end
        checks++; if (out_ports !== 16'h0000) begin errors++; $display("FAIL reset_out_ports: got %h want 0000", out_ports); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_out_write();
        bus(CMD_WR, 9'h100, 16'hABCD);
        checks++; if (out_ports !== 16'h00CD) begin errors++; $display("FAIL out_write: got %h want 00CD", out_ports); end
        bus(CMD_RD, 9'h100, 16'h0000);
        checks++; if (read_data !== 16'h00CD) begin errors++; $display("FAIL out_read_data: got %h want 00CD", read_data); end
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL out_read_hit: got %b want 1", rd_hit); end
        idle(1);
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL idle_rd_hit: got %b want 0", rd_hit); end
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL idle_read_data: got %h want 0000", read_data); end
    endtask

    task automatic test_back_to_back();
        bus(CMD_WR, 9'h101, 16'h1234);
        bus(CMD_RD, 9'h101, 16'h0000);
        checks++; if (read_data !== 16'h0034 || rd_hit !== 1'b1) begin errors++; $display("FAIL raw_out1: got %h hit %b want 0034 hit 1", read_data, rd_hit); end
        checks++; if (out_ports !== 16'h34CD) begin errors++; $display("FAIL out_ports_both: got %h want 34CD", out_ports); end
        bus(CMD_WR, 9'h100, 16'hFF11);
        bus(CMD_RD, 9'h100, 16'h0000);
        checks++; if (read_data !== 16'h0011 || rd_hit !== 1'b1) begin errors++; $display("FAIL raw_out0: got %h hit %b want 0011 hit 1", read_data, rd_hit); end
        checks++; if (out_ports !== 16'h3411) begin errors++; $display("FAIL out_ports_b2b: got %h want 3411", out_ports); end
    endtask

    task automatic test_in_port();
        in_ports = 16'h5A00;
        idle(2);
        bus(CMD_RD, 9'h141, 16'h0000);
        checks++; if (read_data !== 16'h005A || rd_hit !== 1'b1) begin errors++; $display("FAIL in1_read: got %h hit %b want 005A hit 1", read_data, rd_hit); end
        bus(CMD_RD, 9'h140, 16'h0000);
        checks++; if (read_data !== 16'h0000 || rd_hit !== 1'b1) begin errors++; $display("FAIL in0_read: got %h hit %b want 0000 hit 1", read_data, rd_hit); end
        bus(CMD_WR, 9'h141, 16'hFFFF);
        checks++; if (out_ports !== 16'h3411) begin errors++; $display("FAIL in_write_ignored: got %h want 3411", out_ports); end
        bus(CMD_RD, 9'h141, 16'h0000);
        checks++; if (read_data !== 16'h005A) begin errors++; $display("FAIL in1_after_write: got %h want 005A", read_data); end
    endtask

    task automatic test_undecoded();
        logic [8:0] addrs [5];
        addrs = '{9'h102, 9'h142, 9'h0FF, 9'h1C0, 9'h000};
        for (int k = 0; k < 5; k++) begin
            bus(CMD_RD, 9'h100, 16'h0000);
            bus(CMD_RD, addrs[k], 16'h0000);
            checks++; if (rd_hit !== 1'b0 || read_data !== 16'h0000) begin errors++; $display("FAIL undecoded_read %h: got %h hit %b want 0000 hit 0", addrs[k], read_data, rd_hit); end
        end
        bus(CMD_WR, 9'h102, 16'hAAAA);
        bus(CMD_WR, 9'h000, 16'hBBBB);
        bus(CMD_WR, 9'h0FF, 16'hCCCC);
        bus(CMD_WR, 9'h1C1, 16'hDDDD);
        checks++; if (out_ports !== 16'h3411) begin errors++; $display("FAIL undecoded_write: got %h want 3411", out_ports); end
    endtask

`ifdef MMIO_EDGE_CAPTURE_EN
    task automatic test_edge_capture();
        // Port 1 rose to 5A earlier, so its sticky bits reflect that.
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_from_in1: got %b want 1", irq); end
        bus(CMD_RD, 9'h181, 16'h0000);
        checks++; if (read_data !== 16'h005A || rd_hit !== 1'b1) begin errors++; $display("FAIL stat1_read: got %h hit %b want 005A hit 1", read_data, rd_hit); end
        bus(CMD_WR, 9'h181, 16'h00FF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL stat1_clear_irq: got %b want 0", irq); end

        in_ports = 16'h5A01;
        idle(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL stat0_early: got %b want 0", irq); end
        idle(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL stat0_set_irq: got %b want 1", irq); end
        bus(CMD_RD, 9'h180, 16'h0000);
        bus(CMD_RD, 9'h180, 16'h0000);
        checks++; if (read_data !== 16'h0001 || rd_hit !== 1'b1) begin errors++; $display("FAIL stat0_read_sticky: got %h hit %b want 0001 hit 1", read_data, rd_hit); end
        bus(CMD_WR, 9'h180, 16'hFFFE);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL stat0_w0_keeps: got %b want 1", irq); end
        bus(CMD_WR, 9'h180, 16'h0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL stat0_clear: got %b want 0", irq); end

        in_ports = 16'h5A00;
        idle(3);
        in_ports = 16'h5A01;
        idle(2);
        bus(CMD_WR, 9'h180, 16'h0001);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq); end
        bus(CMD_RD, 9'h180, 16'h0000);
        checks++; if (read_data !== 16'h0001) begin errors++; $display("FAIL set_wins_stat: got %h want 0001", read_data); end
    endtask
`else
    task automatic test_no_edge_capture();
        bus(CMD_RD, 9'h180, 16'h0000);
        checks++; if (rd_hit !== 1'b0 || read_data !== 16'h0000) begin errors++; $display("FAIL stat_absent_read: got %h hit %b want 0000 hit 0", read_data, rd_hit); end
        in_ports = 16'h5AFF;
        idle(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied_low: got %b want 0", irq); end
        bus(CMD_WR, 9'h180, 16'hFFFF);
        bus(CMD_RD, 9'h140, 16'h0000);
        checks++; if (read_data !== 16'h00FF || rd_hit !== 1'b1) begin errors++; $display("FAIL in0_nomacro: got %h hit %b want 00FF hit 1", read_data, rd_hit); end
        checks++; if (out_ports !== 16'h3411) begin errors++; $display("FAIL stat_write_ignored: got %h want 3411", out_ports); end
    endtask
`endif

    task automatic test_async_reset();
        bus(CMD_WR, 9'h100, 16'h0077);
        bus(CMD_RD, 9'h100, 16'h0000);
        checks++; if (rd_hit !== 1'b1 || read_data !== 16'h0077) begin errors++; $display("FAIL pre_reset_read: got %h hit %b want 0077 hit 1", read_data, rd_hit); end
`ifdef MMIO_EDGE_CAPTURE_EN
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
`endif
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_ports !== 16'h0000) begin errors++; $display("FAIL async_out_ports: got %h want 0000", out_ports); end
        checks++; if (rd_hit !== 1'b0 || read_data !== 16'h0000) begin errors++; $display("FAIL async_rd_hit: got %h hit %b want 0000 hit 0", read_data, rd_hit); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want 0", irq); end
        #1;
        reset = 1'b0;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_back_to_back();
        test_in_port();
        test_undecoded();
`ifdef MMIO_EDGE_CAPTURE_EN
        test_edge_capture();
`else
        test_no_edge_capture();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_port_bank.md
# mmio_port_bank

Parametrised memory-mapped I/O port bank sitting beside the data RAM on the CPU's `mem_cmd`/`mem_addr` bus. It provides N_OUT writable output registers (LED-style), N_IN synchronised input ports (switch-style) and, optionally, sticky rising-edge status bits with an interrupt line. Read data is registered so its latency matches the synchronous RAM. The top level selects between RAM `dout` and this block using `rd_hit`.

## Interface
Parameters:
- `DATA_W`, 16, CPU data bus width
- `ADDR_W`, 9, CPU address width
- `PORT_W`, 8, width of each port, must satisfy 1 ≤ PORT_W ≤ DATA_W
- `N_OUT`, 2, number of output registers, 1..64
- `N_IN`, 2, number of input ports, 1..64
- `BASE_ADDR`, 9'h100, base of the 256-word I/O window; the low 8 bits must be 0

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_cmd`  in  2  2'b00 none, 2'b01 read, 2'b11 write; 2'b10 behaves as none
- `mem_addr`  in  ADDR_W  word address
- `write_data`  in  DATA_W  CPU store data
- `read_data`  out  DATA_W  registered read data; 0 when `rd_hit`=0
- `rd_hit`  out  1  registered; high when `read_data` is valid from this block
- `in_ports`  in  N_IN*PORT_W  asynchronous inputs; port i is `[i*PORT_W +: PORT_W]`
- `out_ports`  out  N_OUT*PORT_W  output register contents, same packing
- `irq`  out  1  OR of all status bits (see Configuration)

## Operation
- Address map, with off = `mem_addr` − BASE_ADDR and decode applied only when `mem_addr[ADDR_W-1:8]` equals `BASE_ADDR[ADDR_W-1:8]`:
  - off 0x00+i, i<N_OUT: OUT[i], read/write
  - off 0x40+i, i<N_IN: IN[i], read-only, returns the synchronised value
  - off 0x80+i, i<N_IN: STAT[i], read / write-1-to-clear (only with the macro defined)
- Any other address is not decoded. Writes to it are ignored and reads give `rd_hit`=0.
- Write (`mem_cmd`=2'b11, decoded OUT[i]): OUT[i] ← `write_data[PORT_W-1:0]`. Upper bits are ignored.
- Writes to IN addresses are ignored.
- Read (`mem_cmd`=2'b01, decoded): the addressed value, zero-extended to DATA_W, is registered into `read_data` and `rd_hit` is set.
- Any cycle without a decoded read sets `rd_hit`←0 and `read_data`←0.
- Inputs pass through a 2-flop synchroniser per bit: sync1 ← `in_ports`, sync2 ← sync1. IN[i] reads sync2.
- Edge capture: a third flop stage (prev ← sync2) feeds detection. A bit with sync2=1 and prev=0 sets the corresponding STAT bit.
- STAT clear: a write to STAT[i] clears each bit where `write_data[b]`=1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Reading STAT never clears it.
- Reset values: all OUT = 0, `out_ports` = 0, sync/prev flops = 0, STAT = 0, `read_data` = 0, `rd_hit` = 0, `irq` = 0.
- Reset asserted mid-read drops `rd_hit` immediately (asynchronous reset).

## Timing
- Write latency: `out_ports` changes on the edge that samples the write, i.e. it is visible in the next cycle.
- Read latency: 1 cycle. Data for a read presented in cycle n appears in cycle n+1, the same as RAM `dout`.
- Read-after-write to the same OUT in consecutive cycles returns the new value.
- Input latency: an `in_ports` change is readable via IN 2 edges later. A rising edge sets STAT 3 edges after the change.
- `irq` is combinational from the STAT flops, so it is high in the cycle after STAT is set.
- Back-to-back reads and writes are accepted every cycle; there is no stall and no handshake.

## Configuration
- Controlled by the macro `MMIO_EDGE_CAPTURE_EN`.
- Defined: the prev flops, STAT registers, STAT decode at off 0x80+i and `irq` are all present.
- Undefined: none of that logic exists. STAT addresses are not decoded (`rd_hit`=0, writes ignored) and `irq` is tied to 0. OUT and IN behaviour is unchanged.

## Test plan
- Reset, then write 16'hABCD to 0x100 → `out_ports[7:0]`=8'hCD the next cycle. A read of 0x100 returns 16'h00CD with `rd_hit`=1 one cycle later.
- Set `in_ports[15:8]`=8'h5A and wait 2 edges, then read 0x141 → `read_data`=16'h005A, `rd_hit`=1. Also write to 0x141 → no change to any state.
- Read 0x102, 0x142 and 0x0FF (RAM space) with N_OUT=N_IN=2 → `rd_hit`=0 and `read_data`=0 on the following cycle.
- With the macro defined: toggle `in_ports[0]` 0→1 → STAT[0] bit0=1 after 3 edges and `irq`=1. Write 16'h0001 to 0x180 → bit cleared and `irq`=0. A clear that coincides with a new rising edge leaves the bit set.
- Assert `reset` asynchronously between clock edges after OUT writes and a pending read → `out_ports`=0, `rd_hit`=0 and `irq`=0 immediately, before the next edge.
- Build without the macro: read 0x180 → `rd_hit`=0. Edges on `in_ports` → `irq` stays 0.
